sdr_16_responder: RTL and testbench

- Synthesizable responder for the 16-bit SDR SDRAM command interface: the device end of the link driven by the controller FSM.
- Decodes ba/a/cmd each sdram_clk edge and tracks the mode register, per-bank open rows and burst progress.
- Serves write and read data through a synchronous backing-memory port, returning read data after the programmed CAS latency.
- Flags protocol violations; used as a bench/FPGA-loopback stand-in for a real SDRAM.

---
 rtl/sdr_16_pkg.sv | 62 ++++++
 rtl/sdr_16_rd_pipe.sv | 56 +++++
 rtl/sdr_16_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_sdr_16_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_16_pkg.sv
// Shared definitions for the 16-bit SDR SDRAM responder.
//   - geometry constants (bank/row/column/data widths, memory address width)
//   - command encodings {ras_n,cas_n,we_n}, burst-engine states, error codes
//   - burst_col(): column of beat i inside a BL-aligned wrap block
package sdr_16_pkg;

  localparam int BA_SIZE   = 2;
  localparam int ROW_SIZE  = 13;
  localparam int COL_SIZE  = 9;
  localparam int DW        = 16;
  localparam int ADR_W     = BA_SIZE + ROW_SIZE + COL_SIZE;
  localparam int NUM_BANKS = 1 << BA_SIZE;
  localparam int AP_BIT    = 10;  // auto-precharge / precharge-all address bit

  typedef enum logic [2:0] {
    CMD_LMR  = 3'b000,
    CMD_RFR  = 3'b001,
    CMD_PCH  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_RSVD = 3'b110,  // burst-terminate on real parts; treated as nop here
    CMD_NOP  = 3'b111
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_MODE        = 3'd1,  // unsupported CL or BL code in LMR
    ERR_ACT_OPEN    = 3'd2,  // ACT to a bank that is already open
    ERR_RFR_OPEN    = 3'd3,  // refresh with a bank still open
    ERR_BANK_CLOSED = 3'd4,  // RD/WR to a closed bank
    ERR_NO_MODE     = 3'd5,  // RD/WR before any valid LMR
    ERR_LMR_BURST   = 3'd6   // LMR while a burst is running
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } burst_state_t;

  localparam logic [2:0] CL_2 = 3'd2;
  localparam logic [2:0] CL_3 = 3'd3;
  localparam logic [2:0] BL_1 = 3'd0;
  localparam logic [2:0] BL_8 = 3'd3;

  // Low log2(BL) bits advance (sequential) or are XORed (interleaved);
  // the upper bits stay fixed so the burst wraps inside its aligned block.
  function automatic logic [COL_SIZE-1:0] burst_col(
    input logic [COL_SIZE-1:0] c,
    input logic [2:0]          i,
    input logic [1:0]          bl_code,
    input logic                bt
  );
    logic [COL_SIZE-1:0] mask;
    logic [COL_SIZE-1:0] off;
    mask = COL_SIZE'((4'd1 << bl_code) - 4'd1);
    off  = bt ? (c ^ COL_SIZE'(i)) : (c + COL_SIZE'(i));
    return (c & ~mask) | (off & mask);
  endfunction

endpackage

// File: rtl/sdr_16_rd_pipe.sv
// CAS-latency delay line for read data.
//   sdram_clk, sdram_rst : clock / synchronous active-high flush
//   cl3                  : 1 = take the registered stage (CL3), 0 = pass through (CL2)
//   in_valid, in_data    : memory read data, valid the cycle after the read strobe
//   out_valid, out_data  : dq_oe / dq_o; data is forced to 0 when not valid
module sdr_16_rd_pipe
  import sdr_16_pkg::*;
#(
  parameter int MAX_EXTRA = 1
) (
  input  logic          sdram_clk,
  input  logic          sdram_rst,
  input  logic          cl3,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          stage_valid_reg [MAX_EXTRA];
  logic [DW-1:0] stage_data_reg  [MAX_EXTRA];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_EXTRA; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge sdram_clk) begin
          if (sdram_rst) begin
            stage_valid_reg[gi] <= 1'b0;
            stage_data_reg[gi]  <= '0;
          end else begin
            stage_valid_reg[gi] <= in_valid;
            stage_data_reg[gi]  <= in_data;
          end
        end
      end else begin : g_chain
        always_ff @(posedge sdram_clk) begin
          if (sdram_rst) begin
            stage_valid_reg[gi] <= 1'b0;
            stage_data_reg[gi]  <= '0;
          end else begin
            stage_valid_reg[gi] <= stage_valid_reg[gi-1];
            stage_data_reg[gi]  <= stage_data_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    out_valid = cl3 ? stage_valid_reg[MAX_EXTRA-1] : in_valid;
    out_data  = '0;
    if (out_valid) out_data = cl3 ? stage_data_reg[MAX_EXTRA-1] : in_data;
  end

endmodule

// File: rtl/sdr_16_responder.sv
// Device-side responder for a 16-bit SDR SDRAM command interface.
//   sdram_clk, sdram_rst      : clock / synchronous active-high reset
//   ba, a, cmd                : command bus sampled every edge
//   dq_i                      : write data (with WR and each following beat)
//   dq_o, dq_oe               : read data returned CL cycles after RD
//   mem_adr/we/re/wdata/rdata : synchronous backing memory, address {ba,row,col}
//   mode_valid                : a valid LMR has been received
//   err, err_code             : sticky protocol error and its first cause
module sdr_16_responder
  import sdr_16_pkg::*;
(
  input  logic                sdram_clk,
  input  logic                sdram_rst,
  input  logic [BA_SIZE-1:0]  ba,
  input  logic [ROW_SIZE-1:0] a,
  input  logic [2:0]          cmd,
  input  logic [DW-1:0]       dq_i,
  output logic [DW-1:0]       dq_o,
  output logic                dq_oe,
  output logic [ADR_W-1:0]    mem_adr,
  output logic                mem_we,
  output logic                mem_re,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                mode_valid,
  output logic                err,
  output logic [2:0]          err_code
);

  cmd_t cmd_dec;
  assign cmd_dec = cmd_t'(cmd);

  logic                bank_open_reg [NUM_BANKS];
  logic [ROW_SIZE-1:0] bank_row_reg  [NUM_BANKS];
  logic                any_open;

  logic       mode_valid_reg, cl3_reg, bt_reg;
  logic [1:0] bl_code_reg;
  logic [2:0] bl_last;
  logic       lmr_ok;

  burst_state_t        state_reg, state_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [BA_SIZE-1:0]  bst_bank_reg, bst_bank_next;
  logic [ROW_SIZE-1:0] bst_row_reg, bst_row_next;
  logic [COL_SIZE-1:0] bst_col_reg, bst_col_next;
  logic                bst_ap_reg, bst_ap_next;

  logic                beat_go, beat_wr, ap_close;
  logic [BA_SIZE-1:0]  beat_bank;
  logic [ROW_SIZE-1:0] beat_row;
  logic [COL_SIZE-1:0] beat_col_w;

  logic            is_rdwr, rdwr_ok, pch_hit;
  logic            err_hit;
  err_t            err_cause;
  logic            err_reg;
  err_t            err_code_reg;
  logic            mem_we_reg, mem_re_reg, re_d1_reg;
  logic [ADR_W-1:0] mem_adr_reg;
  logic [DW-1:0]   mem_wdata_reg;

  assign bl_last = 3'((4'd1 << bl_code_reg) - 4'd1);
  assign lmr_ok  = (a[6:4] == CL_2 || a[6:4] == CL_3) && (a[2:0] <= BL_8);
  assign is_rdwr = (cmd_dec == CMD_RD) || (cmd_dec == CMD_WR);
  assign rdwr_ok = is_rdwr && bank_open_reg[ba] && mode_valid_reg;
  assign pch_hit = (cmd_dec == CMD_PCH) && (a[AP_BIT] || ba == bst_bank_reg);

  always_comb begin
    any_open = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) any_open = any_open | bank_open_reg[b];
  end

  // Burst engine: the start edge issues beat 0 itself, so the counter holds
  // the index of the beat to issue on the following edge.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bst_bank_next = bst_bank_reg;
    bst_row_next  = bst_row_reg;
    bst_col_next  = bst_col_reg;
    bst_ap_next   = bst_ap_reg;
    beat_go       = 1'b0;
    beat_wr       = (state_reg == ST_WRITE);
    ap_close      = 1'b0;
    beat_bank     = bst_bank_reg;
    beat_row      = bst_row_reg;
    beat_col_w    = burst_col(bst_col_reg, cnt_reg, bl_code_reg, bt_reg);
    if (rdwr_ok) begin
      bst_bank_next = ba;
      bst_row_next  = bank_row_reg[ba];
      bst_col_next  = a[COL_SIZE-1:0];
      bst_ap_next   = a[AP_BIT];
      beat_go       = 1'b1;
      beat_wr       = (cmd_dec == CMD_WR);
      beat_bank     = ba;
      beat_row      = bank_row_reg[ba];
      beat_col_w    = a[COL_SIZE-1:0];
      cnt_next      = 3'd1;
      if ({1'b0, bl_code_reg} == BL_1) begin
        state_next = ST_IDLE;
        ap_close   = a[AP_BIT];
      end else begin
        state_next = (cmd_dec == CMD_WR) ? ST_WRITE : ST_READ;
      end
    end else if (state_reg != ST_IDLE) begin
      if (is_rdwr) begin
        state_next = ST_IDLE;  // rejected RD/WR still cuts the running burst
      end else begin
        beat_go = 1'b1;
        if (cnt_reg == bl_last) begin
          state_next = ST_IDLE;
          ap_close   = bst_ap_reg;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
        if (pch_hit) state_next = ST_IDLE;
      end
    end
  end

  always_comb begin
    err_hit   = 1'b0;
    err_cause = ERR_NONE;
    case (cmd_dec)
      CMD_LMR: begin
        if (state_reg != ST_IDLE) begin
          err_hit = 1'b1; err_cause = ERR_LMR_BURST;
        end else if (!lmr_ok) begin
          err_hit = 1'b1; err_cause = ERR_MODE;
        end
      end
      CMD_ACT: if (bank_open_reg[ba]) begin
        err_hit = 1'b1; err_cause = ERR_ACT_OPEN;
      end
      CMD_RFR: if (any_open) begin
        err_hit = 1'b1; err_cause = ERR_RFR_OPEN;
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open_reg[ba]) begin
          err_hit = 1'b1; err_cause = ERR_BANK_CLOSED;
        end else if (!mode_valid_reg) begin
          err_hit = 1'b1; err_cause = ERR_NO_MODE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_open_reg[b] <= 1'b0;
        bank_row_reg[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (ap_close && beat_bank == BA_SIZE'(b)) begin
          bank_open_reg[b] <= 1'b0;
        end else if (cmd_dec == CMD_PCH && (a[AP_BIT] || ba == BA_SIZE'(b))) begin
          bank_open_reg[b] <= 1'b0;
        end else if (cmd_dec == CMD_ACT && ba == BA_SIZE'(b) && !bank_open_reg[b]) begin
          bank_open_reg[b] <= 1'b1;
          bank_row_reg[b]  <= a;
        end
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 3'd0;
      bst_bank_reg   <= '0;
      bst_row_reg    <= '0;
      bst_col_reg    <= '0;
      bst_ap_reg     <= 1'b0;
      mode_valid_reg <= 1'b0;
      cl3_reg        <= 1'b0;
      bt_reg         <= 1'b0;
      bl_code_reg    <= 2'd0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      mem_we_reg     <= 1'b0;
      mem_re_reg     <= 1'b0;
      mem_adr_reg    <= '0;
      mem_wdata_reg  <= '0;
      re_d1_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bst_bank_reg <= bst_bank_next;
      bst_row_reg  <= bst_row_next;
      bst_col_reg  <= bst_col_next;
      bst_ap_reg   <= bst_ap_next;
      if (cmd_dec == CMD_LMR && state_reg == ST_IDLE && lmr_ok) begin
        mode_valid_reg <= 1'b1;
        cl3_reg        <= (a[6:4] == CL_3);
        bt_reg         <= a[3];
        bl_code_reg    <= a[1:0];
      end
      if (err_hit && !err_reg) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_cause;
      end
      mem_we_reg <= beat_go && beat_wr;
      mem_re_reg <= beat_go && !beat_wr;
      if (beat_go) mem_adr_reg <= {beat_bank, beat_row, beat_col_w};
      if (beat_go && beat_wr) mem_wdata_reg <= dq_i;
      re_d1_reg <= mem_re_reg;  // aligns with mem_rdata
    end
  end

  sdr_16_rd_pipe #(.MAX_EXTRA(1)) u_rd_pipe (
    .sdram_clk (sdram_clk),
    .sdram_rst (sdram_rst),
    .cl3       (cl3_reg),
    .in_valid  (re_d1_reg),
    .in_data   (mem_rdata),
    .out_valid (dq_oe),
    .out_data  (dq_o)
  );

  assign mem_adr    = mem_adr_reg;
  assign mem_we     = mem_we_reg;
  assign mem_re     = mem_re_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mode_valid = mode_valid_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_sdr_16_responder.sv
// Directed bench for sdr_16_responder: a cycle-by-cycle vector table plus
// hand-written sequences for reset mid-burst, auto-precharge and LMR-in-burst.
module tb_sdr_16_responder;

  localparam logic [2:0] LMR = 3'b000, RFR = 3'b001, PCH = 3'b010, ACT = 3'b011;
  localparam logic [2:0] WR  = 3'b100, RD  = 3'b101, NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ba;
  logic [12:0] a;
  logic [2:0]  cmd;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [23:0] mem_adr;
  logic        mem_we, mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mode_valid, err;
  logic [2:0]  err_code;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdr_16_responder dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .ba        (ba),
    .a         (a),
    .cmd       (cmd),
    .dq_i      (dq_i),
    .dq_o      (dq_o),
    .dq_oe     (dq_oe),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mode_valid(mode_valid),
    .err       (err),
    .err_code  (err_code)
  );

  // Backing memory: registered read; unwritten words return 0x0C00 | column.
  logic [15:0] mem_model [logic [23:0]];
  always @(posedge clk) begin
    if (mem_re)
      mem_rdata <= mem_model.exists(mem_adr) ? mem_model[mem_adr]
                                             : (16'h0C00 | {7'd0, mem_adr[8:0]});
    if (mem_we) mem_model[mem_adr] = mem_wdata;
  end

  typedef struct packed {
    logic        rst;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [15:0] dq;
    logic        we;
    logic        re;
    logic [23:0] adr;
    logic [15:0] wd;
    logic        oe;
    logic [15:0] dqo;
    logic        mv;
    logic        er;
    logic [2:0]  code;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [23:0] ad(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
    return {b, r, c};
  endfunction

  task automatic add(input logic r, input logic [2:0] c, input logic [1:0] b, input logic [12:0] aa,
                     input logic [15:0] d, input logic we, input logic re, input logic [23:0] adr,
                     input logic [15:0] wd, input logic oe, input logic [15:0] dqo,
                     input logic mv, input logic er, input logic [2:0] code);
    vec_t v;
    v = '{r, c, b, aa, d, we, re, adr, wd, oe, dqo, mv, er, code};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one command, let the edge sample it, then settle 1 time unit.
  task automatic step(input logic r, input logic [2:0] c, input logic [1:0] b,
                      input logic [12:0] aa, input logic [15:0] d);
    rst = r; cmd = c; ba = b; a = aa; dq_i = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd = NOP; ba = 2'd0; a = 13'd0; dq_i = 16'd0;

    // rst cmd ba a dq | we re adr wd | oe dqo | mv er code
    add(0, LMR, 0, 13'h021, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, ACT, 1, 13'd5,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, WR,  1, 13'd4,   16'h1111, 1, 0, ad(1, 5, 4), 16'h1111, 0, 16'h0,    1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h2222, 1, 0, ad(1, 5, 5), 16'h2222, 0, 16'h0,    1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, RD,  1, 13'd5,   16'h0,    0, 1, ad(1, 5, 5), 16'h0,    0, 16'h0,    1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 1, ad(1, 5, 4), 16'h0,    1, 16'h2222, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          1, 16'h1111, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, LMR, 0, 13'h031, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, RD,  1, 13'd5,   16'h0,    0, 1, ad(1, 5, 5), 16'h0,    0, 16'h0,    1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 1, ad(1, 5, 4), 16'h0,    0, 16'h0,    1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          1, 16'h2222, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          1, 16'h1111, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, LMR, 0, 13'h02A, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, RD,  1, 13'd2,   16'h0,    0, 1, ad(1, 5, 2), 16'h0,    0, 16'h0,    1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 1, ad(1, 5, 3), 16'h0,    1, 16'h0C02, 1, 0, 0);
    add(0, RD,  1, 13'd8,   16'h0,    0, 1, ad(1, 5, 8), 16'h0,    1, 16'h0C03, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 1, ad(1, 5, 9), 16'h0,    1, 16'h0C08, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 1, ad(1, 5, 10), 16'h0,   1, 16'h0C09, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 1, ad(1, 5, 11), 16'h0,   1, 16'h0C0A, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          1, 16'h0C0B, 1, 0, 0);
    add(0, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, RD,  0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 1, 4);
    add(0, ACT, 1, 13'd7,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 1, 4);
    add(1, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, LMR, 0, 13'h021, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, ACT, 2, 13'd3,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 0, 0);
    add(0, RFR, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 1, 3);
    add(1, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, ACT, 2, 13'd3,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, PCH, 0, 13'h400, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, RFR, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, ACT, 0, 13'd1,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, WR,  0, 13'd0,   16'h5555, 0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 1, 5);
    add(1, NOP, 0, 13'd0,   16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 0, 0);
    add(0, LMR, 0, 13'h041, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    0, 1, 1);
    add(0, LMR, 0, 13'h021, 16'h0,    0, 0, 24'h0, 16'h0,          0, 16'h0,    1, 1, 1);

    // Reset state
    step(1, NOP, 0, 0, 0);
    step(1, NOP, 0, 0, 0);
    chk("rst.dq_o", dq_o, 0);       chk("rst.dq_oe", dq_oe, 0);
    chk("rst.mem_we", mem_we, 0);   chk("rst.mem_re", mem_re, 0);
    chk("rst.mem_adr", mem_adr, 0); chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mode_valid", mode_valid, 0);
    chk("rst.err", err, 0);         chk("rst.err_code", err_code, 0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      step(v.rst, v.cmd, v.ba, v.a, v.dq);
      chk($sformatf("v%0d.mem_we", i), mem_we, v.we);
      chk($sformatf("v%0d.mem_re", i), mem_re, v.re);
      if (v.we || v.re || v.rst) chk($sformatf("v%0d.mem_adr", i), mem_adr, v.adr);
      if (v.we || v.rst) chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v.wd);
      chk($sformatf("v%0d.dq_oe", i), dq_oe, v.oe);
      if (v.oe || v.rst) chk($sformatf("v%0d.dq_o", i), dq_o, v.dqo);
      chk($sformatf("v%0d.mode_valid", i), mode_valid, v.mv);
      chk($sformatf("v%0d.err", i), err, v.er);
      chk($sformatf("v%0d.err_code", i), err_code, v.code);
      $display("[TB] vec %0d rst=%0d cmd=%b ba=%0d a=%h -> we=%0d re=%0d adr=%h oe=%0d dq_o=%h err=%0d/%0d",
               i, v.rst, v.cmd, v.ba, v.a, mem_we, mem_re, mem_adr, dq_oe, dq_o, err, err_code);
    end

    // Reset in the middle of a BL8 write burst
    step(1, NOP, 0, 0, 0);
    step(0, LMR, 0, 13'h023, 0);
    step(0, ACT, 3, 13'd9, 0);
    step(0, WR, 3, 13'd0, 16'hAA00);
    chk("rstwr.beat0.we", mem_we, 1); chk("rstwr.beat0.adr", mem_adr, ad(3, 9, 0));
    step(0, NOP, 0, 0, 16'hAA01);
    chk("rstwr.beat1.adr", mem_adr, ad(3, 9, 1)); chk("rstwr.beat1.wd", mem_wdata, 16'hAA01);
    step(1, NOP, 0, 0, 16'hAA02);
    chk("rstwr.we", mem_we, 0); chk("rstwr.oe", dq_oe, 0); chk("rstwr.mv", mode_valid, 0);
    step(0, NOP, 0, 0, 16'hAA03);
    chk("rstwr.after.we", mem_we, 0); chk("rstwr.after.re", mem_re, 0);
    $display("[TB] seq reset-mid-write done");

    // Auto-precharge closes the bank after the last beat
    step(0, LMR, 0, 13'h021, 0);
    step(0, ACT, 3, 13'd9, 0);
    step(0, WR, 3, 13'h400, 16'hBB00);
    step(0, NOP, 0, 0, 16'hBB01);
    chk("ap.beat1.adr", mem_adr, ad(3, 9, 1)); chk("ap.beat1.wd", mem_wdata, 16'hBB01);
    step(0, NOP, 0, 0, 0);
    chk("ap.idle.we", mem_we, 0);
    step(0, RD, 3, 13'd0, 0);
    chk("ap.rd.re", mem_re, 0); chk("ap.rd.err", err, 1); chk("ap.rd.code", err_code, 4);
    $display("[TB] seq auto-precharge done");

    // LMR while a read burst runs is rejected; CL stays 2
    step(1, NOP, 0, 0, 0);
    step(0, LMR, 0, 13'h021, 0);
    step(0, ACT, 0, 13'd1, 0);
    step(0, RD, 0, 13'd0, 0);
    chk("lmrb.beat0.adr", mem_adr, ad(0, 1, 0));
    step(0, LMR, 0, 13'h031, 0);
    chk("lmrb.beat1.adr", mem_adr, ad(0, 1, 1)); chk("lmrb.err", err, 1);
    chk("lmrb.code", err_code, 6); chk("lmrb.oe0", dq_oe, 1); chk("lmrb.dq0", dq_o, 16'h0C00);
    step(0, NOP, 0, 0, 0);
    chk("lmrb.oe1", dq_oe, 1); chk("lmrb.dq1", dq_o, 16'h0C01);
    step(0, NOP, 0, 0, 0);
    chk("lmrb.oe2", dq_oe, 0);
    $display("[TB] seq lmr-in-burst done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
